if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the PC and issues word fetches to instruction memory over a single-outstanding request/response interface with variable latency.
- Produces the IF/ID register contents (Curr_Pc, Curr_Instr) plus a valid bit.
- Accepts stall from the hazard unit, branch/jump redirect from EX, and a halt.

Parameters:
- PC_W, 9, PC / instruction-memory byte-address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 9'd0, PC loaded on reset.
- NOP_INSTR, 32'h00000013, instruction driven on bubbles (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  one-cycle fetch request strobe.
- imem_addr  out  PC_W  fetch byte address; valid when imem_req=1.
- imem_rvalid  in  1  response strobe; exactly one per request, at least 1 cycle after the request.
- imem_rdata  in  INSTR_W  fetched instruction; valid when imem_rvalid=1.
- stall  in  1  ID stage cannot accept; the IF/ID outputs hold.
- br_taken  in  1  redirect from EX (branch taken / jal / jalr).
- br_target  in  PC_W  redirect PC.
- halt  in  1  stop fetching; sticky internally until reset.
- if_id_valid  out  1  IF/ID entry holds a real instruction.
- if_id_curr_pc  out  PC_W  PC of the instruction in IF/ID.
- if_id_curr_instr  out  INSTR_W  instruction in IF/ID.

Behaviour:
- Clocking and reset: single clk domain; reset is asynchronous and active-high.
- Reset values: state=FETCH, pc_q=RESET_PC, halt_q=0, buffer empty, imem_req=0, imem_addr=RESET_PC, if_id_valid=0, if_id_curr_pc=0, if_id_curr_instr=NOP_INSTR.
- Reset mid-operation: everything is reinitialised immediately. Any response arriving after reset deasserts without a matching post-reset request is ignored, because state is FETCH, not WAIT.
- PC arithmetic: pc_q+4 modulo 2^PC_W (508 -> 0). br_target is used as-is, with no alignment check.
- halt_q is set when halt=1; cleared only by reset.
- issue = (state==FETCH || (state==WAIT && imem_rvalid && !stall)) && !br_taken && !halt && !halt_q.
- imem_req = issue.
- imem_addr = the address of the request being issued: pc_q in FETCH; pc_q+4 when issuing from WAIT.
- At most one request is outstanding at any time.

State machine:
- FETCH
  - issue: go to WAIT.
  - br_taken: pc_q<=br_target, stay in FETCH.
  - halt or halt_q: go to HALTED.
- WAIT (request outstanding)
  - rvalid && br_taken: discard the response, pc_q<=br_target, go to FETCH.
  - rvalid && !stall: response goes to IF/ID (valid=1, pc=pc_q, instr=rdata), pc_q<=pc_q+4. Stay in WAIT if issue (back-to-back, one instruction per cycle at 1-cycle memory latency); else HALTED if halt/halt_q; else FETCH.
  - rvalid && stall: response goes to the 1-entry buffer (pc, instr), pc_q<=pc_q+4, go to HOLD.
  - !rvalid && br_taken: pc_q<=br_target, go to DRAIN.
- DRAIN: wait for rvalid, discard it, go to FETCH (or HALTED if halt_q). A further br_taken in DRAIN overwrites pc_q.
- HOLD: buffer full, no requests issued.
  - br_taken: clear the buffer, go to FETCH (pc_q<=br_target).
  - !stall: buffer goes to IF/ID, then go to FETCH (or HALTED if halt_q).
- HALTED: no requests, br_taken ignored, IF/ID drains to a bubble on the first !stall cycle. Exit only by reset.

IF/ID output update rules, per edge, in priority order:
1. br_taken: valid<=0, instr<=NOP_INSTR, pc held. Overrides stall.
2. stall: hold all three outputs.
3. Otherwise: load the response (WAIT, non-discarded rvalid) or the buffer (HOLD). If neither is available, load a bubble.

Latency: reset released before cycle 1, 1-cycle memory: request in cycle 1, rvalid in cycle 2, if_id_valid=1 in cycle 3.

Test Plan:
1. Reset release, 1-cycle memory returning addr-based data: imem_addr sequence 0,4,8,12 on consecutive cycles; if_id outputs (0,I0),(4,I4),... one per cycle from cycle 3; wrap after pc 508 -> 0.
2. Stall for 3 cycles while a response is in flight: the response lands in the buffer, imem_req=0 during HOLD, IF/ID holds its previous value, the buffered instruction appears the cycle after stall drops, and no instruction is lost or duplicated.
3. Memory latency 3; br_taken with target 0x40 one cycle after the request to 0x10: the 0x10 response is discarded (never valid in IF/ID), the next request is 0x40 in the cycle after that rvalid, and IF/ID is a bubble (valid=0, instr=0x00000013) immediately.
4. br_taken and stall asserted together in HOLD: the buffer is cleared, IF/ID becomes a bubble despite stall, and the next request is to br_target.
5. halt pulse while WAIT is outstanding: the pending response is still delivered, no further imem_req ever occurs, later br_taken is ignored, and if_id_valid falls to 0 after the drain.
6. Async reset asserted mid-WAIT, between clock edges: outputs go to reset values without a clock edge, and a stale rvalid after release is ignored; the first request is to RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word fetches
// to instruction memory and fills the IF/ID register (pc, instr, valid).
//
// state   | meaning
// --------+---------------------------------------------------------------
// FETCH   | no request outstanding; issue a fetch at pc_q
// WAIT    | one request outstanding; the response is consumed for pc_q
// DRAIN   | a redirect arrived while a request was outstanding; drop its reply
// HOLD    | reply parked in the 1-entry buffer while ID is stalled
// HALTED  | fetching stopped; only reset leaves this state
module if_fetch_stage #(
    parameter int unsigned            PC_W      = 9,
    parameter int unsigned            INSTR_W   = 32,
    parameter logic [PC_W-1:0]        RESET_PC  = 9'd0,
    parameter logic [INSTR_W-1:0]     NOP_INSTR = 32'h00000013
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    input  logic               halt,
    output logic               if_id_valid,
    output logic [PC_W-1:0]    if_id_curr_pc,
    output logic [INSTR_W-1:0] if_id_curr_instr
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               halt_q, halt_d;
    logic [PC_W-1:0]    buf_pc_q, buf_pc_d;
    logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
    logic               valid_q, valid_d;
    logic [PC_W-1:0]    cur_pc_q, cur_pc_d;
    logic [INSTR_W-1:0] cur_instr_q, cur_instr_d;

    logic [PC_W-1:0]    pc_plus4;
    logic               halting;
    logic               issue;
    logic               resp_take;
    logic               br_eff;

    // Request generation; reset masks the strobe so a fetch is never issued while held in reset.
    always_comb begin
        pc_plus4  = pc_q + PC_W'(4);
        halting   = halt | halt_q;
        issue     = ((state_q == ST_FETCH) ||
                     ((state_q == ST_WAIT) && imem_rvalid && !stall)) &&
                    !br_taken && !halting;
        imem_req  = issue & ~reset;
        // Issuing from WAIT fetches the word after the one being consumed.
        imem_addr = (state_q == ST_WAIT) ? pc_plus4 : pc_q;
    end

    // Next state, PC, sticky halt and the 1-entry response buffer.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        halt_d      = halt_q | halt;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        resp_take   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (br_taken) begin
                    pc_d = br_target;
                end
                if (halting) begin
                    state_d = ST_HALTED;
                end else if (issue) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (br_taken) begin
                        pc_d    = br_target;
                        state_d = ST_FETCH;
                    end else if (!stall) begin
                        resp_take = 1'b1;
                        pc_d      = pc_plus4;
                        if (issue) begin
                            state_d = ST_WAIT;
                        end else if (halting) begin
                            state_d = ST_HALTED;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end else begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem_rdata;
                        pc_d        = pc_plus4;
                        state_d     = ST_HOLD;
                    end
                end else if (br_taken) begin
                    pc_d    = br_target;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (br_taken) begin
                    pc_d = br_target;
                end
                if (imem_rvalid) begin
                    state_d = halting ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (br_taken) begin
                    pc_d    = br_target;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    state_d = halting ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // IF/ID update: redirect flushes (even under stall), stall holds, else load response/buffer/bubble.
    always_comb begin
        valid_d     = valid_q;
        cur_pc_d    = cur_pc_q;
        cur_instr_d = cur_instr_q;
        br_eff      = br_taken && (state_q != ST_HALTED);
        if (br_eff) begin
            valid_d     = 1'b0;
            cur_instr_d = NOP_INSTR;
        end else if (!stall) begin
            if (resp_take) begin
                valid_d     = 1'b1;
                cur_pc_d    = pc_q;
                cur_instr_d = imem_rdata;
            end else if (state_q == ST_HOLD) begin
                valid_d     = 1'b1;
                cur_pc_d    = buf_pc_q;
                cur_instr_d = buf_instr_q;
            end else begin
                valid_d     = 1'b0;
                cur_instr_d = NOP_INSTR;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            halt_q      <= 1'b0;
            buf_pc_q    <= '0;
            buf_instr_q <= NOP_INSTR;
            valid_q     <= 1'b0;
            cur_pc_q    <= '0;
            cur_instr_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            halt_q      <= halt_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            valid_q     <= valid_d;
            cur_pc_q    <= cur_pc_d;
            cur_instr_q <= cur_instr_d;
        end
    end

    assign if_id_valid      = valid_q;
    assign if_id_curr_pc    = cur_pc_q;
    assign if_id_curr_instr = cur_instr_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed scenarios plus a randomized run
// checked against a program-order model of requests and IF/ID deliveries.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        br_taken;
    logic [8:0]  br_target;
    logic        halt;
    logic        if_id_valid;
    logic [8:0]  if_id_curr_pc;
    logic [31:0] if_id_curr_instr;

    int checks = 0;
    int errors = 0;

    // memory model state
    bit         mem_pend;
    int         mem_cnt;
    logic [8:0] mem_addr;
    int         mem_lat;
    bit         mem_rand;
    bit         stale_rv;
    bit         overlap;

    // per-cycle samples taken before the active edge
    bit          req_s, rv_s, stall_s, br_s;
    logic [8:0]  addr_s, tgt_s;
    bit          pv_valid;
    logic [8:0]  pv_pc;
    logic [31:0] pv_instr;

    if_fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .stall            (stall),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .halt             (halt),
        .if_id_valid      (if_id_valid),
        .if_id_curr_pc    (if_id_curr_pc),
        .if_id_curr_instr (if_id_curr_instr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] instr_of(input logic [8:0] a);
        return {8'hA5, 15'd0, a};
    endfunction

    // One clock cycle: present memory response, sample, clock, update memory model.
    task automatic tick();
        imem_rvalid = (mem_pend && mem_cnt == 1) || stale_rv;
        imem_rdata  = stale_rv ? 32'hBAD0_0BAD :
                      (imem_rvalid ? instr_of(mem_addr) : 32'hDEAD_BEEF);
        #1;
        req_s    = imem_req;
        addr_s   = imem_addr;
        rv_s     = imem_rvalid;
        stall_s  = stall;
        br_s     = br_taken;
        tgt_s    = br_target;
        pv_valid = if_id_valid;
        pv_pc    = if_id_curr_pc;
        pv_instr = if_id_curr_instr;
        @(posedge clk);
        #1;
        if (rv_s && !stale_rv) mem_pend = 1'b0;
        if (req_s) begin
            if (mem_pend) overlap = 1'b1;
            mem_pend = 1'b1;
            mem_cnt  = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
            mem_addr = addr_s;
        end else if (mem_pend && mem_cnt > 1) begin
            mem_cnt = mem_cnt - 1;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        halt      = 1'b0;
        stale_rv  = 1'b0;
        mem_pend  = 1'b0;
        mem_cnt   = 0;
        overlap   = 1'b0;
        mem_rand  = 1'b0;
        mem_lat   = 1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        halt      = 1'b0;
        stale_rv  = 1'b0;
        mem_pend  = 1'b0;
        overlap   = 1'b0;
        mem_rand  = 1'b0;
        mem_lat   = 1;
        repeat (2) tick();
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 9'd0)
            $display("FAIL reset_req got req=%0b addr=%0d exp req=0 addr=0", imem_req, imem_addr);
        else if (0) errors++;
        if (imem_req !== 1'b0 || imem_addr !== 9'd0) errors++;
        checks++;
        if (if_id_valid !== 1'b0 || if_id_curr_pc !== 9'd0 || if_id_curr_instr !== NOP) begin
            errors++;
            $display("FAIL reset_ifid got v=%0b pc=%0d instr=%h exp v=0 pc=0 instr=%h",
                     if_id_valid, if_id_curr_pc, if_id_curr_instr, NOP);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [8:0] ea, ep;
        do_reset();
        for (int k = 1; k <= 140; k++) begin
            tick();
            ea = 9'(4 * (k - 1));
            checks++;
            if (req_s !== 1'b1 || addr_s !== ea) begin
                errors++;
                $display("FAIL seq_req k=%0d got req=%0b addr=%0d exp req=1 addr=%0d", k, req_s, addr_s, ea);
            end
            checks++;
            if (k == 1) begin
                if (if_id_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL seq_first_bubble got v=%0b exp v=0", if_id_valid);
                end
            end else begin
                ep = 9'(4 * (k - 2));
                if (if_id_valid !== 1'b1 || if_id_curr_pc !== ep || if_id_curr_instr !== instr_of(ep)) begin
                    errors++;
                    $display("FAIL seq_ifid k=%0d got v=%0b pc=%0d instr=%h exp v=1 pc=%0d instr=%h",
                             k, if_id_valid, if_id_curr_pc, if_id_curr_instr, ep, instr_of(ep));
                end
            end
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        repeat (4) tick();
        stall = 1'b1;
        for (int k = 5; k <= 7; k++) begin
            tick();
            checks++;
            if (req_s !== 1'b0 || if_id_valid !== 1'b1 || if_id_curr_pc !== 9'd8 ||
                if_id_curr_instr !== instr_of(9'd8)) begin
                errors++;
                $display("FAIL stall_hold k=%0d got req=%0b v=%0b pc=%0d exp req=0 v=1 pc=8",
                         k, req_s, if_id_valid, if_id_curr_pc);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (req_s !== 1'b0 || if_id_valid !== 1'b1 || if_id_curr_pc !== 9'd12 ||
            if_id_curr_instr !== instr_of(9'd12)) begin
            errors++;
            $display("FAIL stall_release got req=%0b v=%0b pc=%0d exp req=0 v=1 pc=12",
                     req_s, if_id_valid, if_id_curr_pc);
        end
        tick();
        checks++;
        if (req_s !== 1'b1 || addr_s !== 9'd16 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_refetch got req=%0b addr=%0d v=%0b exp req=1 addr=16 v=0",
                     req_s, addr_s, if_id_valid);
        end
        tick();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_curr_pc !== 9'd16 || if_id_curr_instr !== instr_of(9'd16)) begin
            errors++;
            $display("FAIL stall_next got v=%0b pc=%0d exp v=1 pc=16", if_id_valid, if_id_curr_pc);
        end
    endtask

    task automatic test_branch_drain();
        bit found;
        do_reset();
        mem_lat = 3;
        found   = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (req_s && addr_s == 9'h010) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL drain_find_req got none exp req addr=16 within 40 cycles");
        end
        br_taken  = 1'b1;
        br_target = 9'h040;
        tick();
        br_taken  = 1'b0;
        checks++;
        if (req_s !== 1'b0 || if_id_valid !== 1'b0 || if_id_curr_instr !== NOP) begin
            errors++;
            $display("FAIL drain_bubble got req=%0b v=%0b instr=%h exp req=0 v=0 instr=%h",
                     req_s, if_id_valid, if_id_curr_instr, NOP);
        end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            checks++;
            if (req_s !== 1'b0 || if_id_valid !== 1'b0) begin
                errors++;
                $display("FAIL drain_wait got req=%0b v=%0b pc=%0d exp req=0 v=0",
                         req_s, if_id_valid, if_id_curr_pc);
            end
            if (rv_s) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL drain_rvalid got none exp rvalid within 10 cycles");
        end
        tick();
        checks++;
        if (req_s !== 1'b1 || addr_s !== 9'h040) begin
            errors++;
            $display("FAIL drain_target_req got req=%0b addr=%h exp req=1 addr=040", req_s, addr_s);
        end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (if_id_valid === 1'b1) begin
                found = 1'b1;
                checks++;
                if (if_id_curr_pc !== 9'h040 || if_id_curr_instr !== instr_of(9'h040)) begin
                    errors++;
                    $display("FAIL drain_target_ifid got pc=%h instr=%h exp pc=040 instr=%h",
                             if_id_curr_pc, if_id_curr_instr, instr_of(9'h040));
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL drain_target_timeout got v=0 exp v=1 within 10 cycles");
        end
    endtask

    task automatic test_branch_in_hold();
        do_reset();
        repeat (3) tick();
        stall = 1'b1;
        tick();
        checks++;
        if (req_s !== 1'b0 || if_id_valid !== 1'b1 || if_id_curr_pc !== 9'd4) begin
            errors++;
            $display("FAIL hold_enter got req=%0b v=%0b pc=%0d exp req=0 v=1 pc=4",
                     req_s, if_id_valid, if_id_curr_pc);
        end
        br_taken  = 1'b1;
        br_target = 9'h100;
        tick();
        br_taken = 1'b0;
        stall    = 1'b0;
        checks++;
        if (req_s !== 1'b0 || if_id_valid !== 1'b0 || if_id_curr_instr !== NOP) begin
            errors++;
            $display("FAIL hold_flush got req=%0b v=%0b instr=%h exp req=0 v=0 instr=%h",
                     req_s, if_id_valid, if_id_curr_instr, NOP);
        end
        tick();
        checks++;
        if (req_s !== 1'b1 || addr_s !== 9'h100 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_target_req got req=%0b addr=%h v=%0b exp req=1 addr=100 v=0",
                     req_s, addr_s, if_id_valid);
        end
        tick();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_curr_pc !== 9'h100 || if_id_curr_instr !== instr_of(9'h100)) begin
            errors++;
            $display("FAIL hold_target_ifid got v=%0b pc=%h exp v=1 pc=100", if_id_valid, if_id_curr_pc);
        end
    endtask

    task automatic test_halt();
        do_reset();
        mem_lat = 3;
        tick();
        checks++;
        if (req_s !== 1'b1 || addr_s !== 9'd0) begin
            errors++;
            $display("FAIL halt_first_req got req=%0b addr=%0d exp req=1 addr=0", req_s, addr_s);
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();
        tick();
        checks++;
        if (!rv_s || req_s !== 1'b0 || if_id_valid !== 1'b1 || if_id_curr_pc !== 9'd0 ||
            if_id_curr_instr !== instr_of(9'd0)) begin
            errors++;
            $display("FAIL halt_deliver got rv=%0b req=%0b v=%0b pc=%0d exp rv=1 req=0 v=1 pc=0",
                     rv_s, req_s, if_id_valid, if_id_curr_pc);
        end
        br_taken  = 1'b1;
        br_target = 9'h080;
        tick();
        br_taken = 1'b0;
        checks++;
        if (req_s !== 1'b0 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_drain got req=%0b v=%0b exp req=0 v=0", req_s, if_id_valid);
        end
        for (int k = 0; k < 20; k++) begin
            br_taken  = ($urandom_range(0, 3) == 0);
            br_target = 9'($urandom_range(0, 511));
            stall     = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (req_s !== 1'b0 || if_id_valid !== 1'b0) begin
                errors++;
                $display("FAIL halt_quiet k=%0d got req=%0b v=%0b exp req=0 v=0", k, req_s, if_id_valid);
            end
        end
        br_taken = 1'b0;
        stall    = 1'b0;
    endtask

    task automatic test_async_reset();
        bit found;
        do_reset();
        repeat (4) tick();
        mem_lat = 3;
        tick();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_curr_pc !== 9'd12) begin
            errors++;
            $display("FAIL areset_pre got v=%0b pc=%0d exp v=1 pc=12", if_id_valid, if_id_curr_pc);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 9'd0 || if_id_valid !== 1'b0 ||
            if_id_curr_pc !== 9'd0 || if_id_curr_instr !== NOP) begin
            errors++;
            $display("FAIL areset_async got req=%0b addr=%0d v=%0b pc=%0d instr=%h exp 0 0 0 0 %h",
                     imem_req, imem_addr, if_id_valid, if_id_curr_pc, if_id_curr_instr, NOP);
        end
        #1;
        reset    = 1'b0;
        mem_pend = 1'b0;
        stale_rv = 1'b1;
        tick();
        stale_rv = 1'b0;
        checks++;
        if (req_s !== 1'b1 || addr_s !== 9'd0 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_stale got req=%0b addr=%0d v=%0b exp req=1 addr=0 v=0",
                     req_s, addr_s, if_id_valid);
        end
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            tick();
            if (if_id_valid === 1'b1) begin
                found = 1'b1;
                checks++;
                if (if_id_curr_pc !== 9'd0 || if_id_curr_instr !== instr_of(9'd0)) begin
                    errors++;
                    $display("FAIL areset_first got pc=%0d instr=%h exp pc=0 instr=%h",
                             if_id_curr_pc, if_id_curr_instr, instr_of(9'd0));
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL areset_timeout got v=0 exp v=1 within 8 cycles");
        end
    endtask

    // Program-order model: requests follow last+4 or the latest redirect target;
    // IF/ID entries follow the same order, never skipping or repeating a word.
    task automatic test_random();
        logic [8:0] exp_req, exp_del;
        int         delivered;
        do_reset();
        mem_rand  = 1'b1;
        exp_req   = 9'd0;
        exp_del   = 9'd0;
        delivered = 0;
        for (int k = 0; k < 3000; k++) begin
            stall     = ($urandom_range(0, 99) < 25);
            br_taken  = ($urandom_range(0, 99) < 6);
            br_target = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511))
                                                     : 9'({$urandom_range(0, 127), 2'b00});
            tick();
            if (req_s) begin
                checks++;
                if (addr_s !== exp_req || br_s) begin
                    errors++;
                    $display("FAIL rand_req k=%0d got addr=%0d br=%0b exp addr=%0d br=0",
                             k, addr_s, br_s, exp_req);
                end
                exp_req = 9'(addr_s + 9'd4);
            end
            if (br_s) exp_req = tgt_s;
            checks++;
            if (br_s) begin
                if (if_id_valid !== 1'b0 || if_id_curr_instr !== NOP) begin
                    errors++;
                    $display("FAIL rand_flush k=%0d got v=%0b instr=%h exp v=0 instr=%h",
                             k, if_id_valid, if_id_curr_instr, NOP);
                end
                exp_del = tgt_s;
            end else if (stall_s) begin
                if (if_id_valid !== pv_valid || if_id_curr_pc !== pv_pc || if_id_curr_instr !== pv_instr) begin
                    errors++;
                    $display("FAIL rand_stall k=%0d got v=%0b pc=%0d instr=%h exp v=%0b pc=%0d instr=%h",
                             k, if_id_valid, if_id_curr_pc, if_id_curr_instr, pv_valid, pv_pc, pv_instr);
                end
            end else if (if_id_valid === 1'b1) begin
                if (if_id_curr_pc !== exp_del || if_id_curr_instr !== instr_of(exp_del)) begin
                    errors++;
                    $display("FAIL rand_deliver k=%0d got pc=%0d instr=%h exp pc=%0d instr=%h",
                             k, if_id_curr_pc, if_id_curr_instr, exp_del, instr_of(exp_del));
                end
                exp_del = 9'(exp_del + 9'd4);
                delivered++;
            end else begin
                if (if_id_curr_instr !== NOP) begin
                    errors++;
                    $display("FAIL rand_bubble k=%0d got instr=%h exp %h", k, if_id_curr_instr, NOP);
                end
            end
        end
        stall    = 1'b0;
        br_taken = 1'b0;
        checks++;
        if (delivered < 300 || overlap) begin
            errors++;
            $display("FAIL rand_progress got delivered=%0d overlap=%0b exp delivered>=300 overlap=0",
                     delivered, overlap);
        end
    endtask

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        test_reset();
        test_sequential();
        test_stall_hold();
        test_branch_drain();
        test_branch_in_hold();
        test_halt();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
